// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline package: the state encoding and the NOP payload used by every
// pipeline stage register.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // An all-zero payload decodes as NOP in every stage.
    localparam logic [63:0] PIPE_NOP = 64'd0;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register. IN_READY is registered, so upstream never
// sees a combinational path from OUT_READY.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no valid entry; MAIN keeps stale data
// ST_ONE   | MAIN valid and driving OUT_DATA
// ST_FULL  | MAIN and SKID valid; SKID moves to MAIN on consume
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(PIPE_NOP)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             IN_READY,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    input  logic             OUT_READY,
    output logic [1:0]       OCCUPANCY
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, consume;

    assign accept  = IN_VALID & in_ready_q;
    assign consume = OUT_VALID & OUT_READY;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            // Flush wins over everything; SKID contents become don't-care.
            state_d = ST_EMPTY;
            main_d  = RESET_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = IN_DATA;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = IN_DATA;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = IN_DATA;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_EMPTY;
            main_q     <= RESET_DATA;
            skid_q     <= RESET_DATA;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (state_q != ST_EMPTY);
    assign OUT_DATA  = main_q;
    assign OCCUPANCY = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus randomized
// valid/ready traffic compared against a two-deep FIFO reference model.
module tb_pipe_skid_reg;

    localparam int WIDTH = 64;
    localparam logic [WIDTH-1:0] RST_DATA = '0;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: entries held, in order, plus whether MAIN is known to
    // hold RESET_DATA (after reset/flush, before any further transfer).
    logic [WIDTH-1:0] mdl_q[$];
    logic [WIDTH-1:0] obs_q[$];
    bit               mdl_rst_data;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_DATA(RST_DATA)) dut (
        .CLOCK     (clk),
        .RESET     (rst_n),
        .FLUSH     (flush),
        .IN_VALID  (in_valid),
        .IN_DATA   (in_data),
        .IN_READY  (in_ready),
        .OUT_VALID (out_valid),
        .OUT_DATA  (out_data),
        .OUT_READY (out_ready),
        .OCCUPANCY (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("occupancy", 64'(occupancy), 64'(mdl_q.size()));
        chk("out_valid", 64'(out_valid), 64'(mdl_q.size() > 0));
        chk("in_ready",  64'(in_ready),  64'(mdl_q.size() < 2));
        if (mdl_q.size() > 0)
            chk("out_data", out_data, mdl_q[0]);
        else if (mdl_rst_data)
            chk("out_data_rst", out_data, RST_DATA);
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_rst_data = 1'b1;
    endtask

    // Called just after a falling edge: check, drive, probe, advance the model.
    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d,
                               input logic r, input logic f);
        bit acc, con;
        logic rdy_before;
        check_outputs();
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ~r;
        #1;
        rdy_before = in_ready;
        out_ready = r;
        #1;
        chk("in_ready_no_comb", 64'(in_ready), 64'(rdy_before));
        acc = v && (mdl_q.size() < 2);
        con = r && (mdl_q.size() > 0);
        if (f) begin
            model_reset();
        end else begin
            if (out_valid && r) obs_q.push_back(out_data);
            if (con) void'(mdl_q.pop_front());
            if (acc) mdl_q.push_back(d);
            if (acc || con) mdl_rst_data = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int max_occ;
        logic [WIDTH-1:0] rd;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset asserted before any clock edge: outputs must be reset values.
        #1 rst_n = 1'b0;
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_out_data", out_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming 1..4 with OUT_READY held high.
        obs_q.delete();
        max_occ = 0;
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        chk("stream_count", 64'(obs_q.size()), 64'd4);
        for (int i = 0; i < obs_q.size() && i < 4; i++)
            chk("stream_data", obs_q[i], 64'(i + 1));
        chk("stream_max_occ", 64'(max_occ), 64'd1);

        // Backpressure: 0xA, 0xB held, extra offer refused, then drained.
        obs_q.delete();
        drive_cycle(1'b1, 64'hA, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'hB, 1'b0, 1'b0);
        chk("bp_occ_full", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_held", out_data, 64'hA);
        drive_cycle(1'b1, 64'hEE, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        chk("bp_still_a", out_data, 64'hA);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("bp_first", obs_q[0], 64'hA);
            chk("bp_second", obs_q[1], 64'hB);
        end
        chk("bp_ready_back", 64'(in_ready), 64'd1);

        // Flush while FULL with a simultaneous offer and consume.
        obs_q.delete();
        drive_cycle(1'b1, 64'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'h22, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'hC, 1'b1, 1'b1);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_data", out_data, RST_DATA);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("flush_no_output", 64'(obs_q.size()), 64'd0);

        // Reset pulse between edges while FULL.
        drive_cycle(1'b1, 64'h33, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'h44, 1'b0, 1'b0);
        check_outputs();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("midrst_data", out_data, RST_DATA);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b1, 64'h55, 1'b0, 1'b0);
        chk("midrst_latency_valid", 64'(out_valid), 64'd1);
        chk("midrst_latency_data", out_data, 64'h55);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic against the reference FIFO.
        for (int i = 0; i < 10000; i++) begin
            rd = {$urandom, $urandom};
            drive_cycle(1'($urandom_range(0, 3) != 0), rd,
                        1'($urandom_range(0, 2) != 0),
                        1'($urandom_range(0, 199) == 0));
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning payload width in bits (instruction plus PC+4 for the IF/ID stage).
REQ-002 SHALL have parameter RESET_DATA, default 0 (WIDTH bits), meaning the payload presented after reset and flush (all-zero encodes NOP).
REQ-003 SHALL have port CLOCK  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port FLUSH  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port IN_VALID  input  1  upstream offers IN_DATA.
REQ-007 SHALL have port IN_DATA  input  WIDTH  upstream payload.
REQ-008 SHALL have port IN_READY  output  1  stage accepts a payload this cycle; registered, never combinationally dependent on OUT_READY.
REQ-009 SHALL have port OUT_VALID  output  1  OUT_DATA holds a valid payload.
REQ-010 SHALL have port OUT_DATA  output  WIDTH  downstream payload, driven directly from the main register.
REQ-011 SHALL have port OUT_READY  input  1  downstream consumes the payload this cycle.
REQ-012 SHALL have port OCCUPANCY  output  2  entry count: 0, 1 or 2.

Function
REQ-013 SHALL treat a transfer as occurring on IN_VALID&IN_READY (accept) or OUT_VALID&OUT_READY (consume) at a rising edge.
REQ-014 SHALL hold two entries, MAIN and SKID, with states EMPTY (0 entries), ONE (MAIN valid) and FULL (MAIN and SKID valid).
REQ-015 SHALL transition EMPTY -> ONE on accept, loading MAIN; otherwise remain in EMPTY.
REQ-016 SHALL, in ONE: on accept with consume, stay in ONE with MAIN <= IN_DATA; on accept without consume, go to FULL with SKID <= IN_DATA; on consume without accept, go to EMPTY; otherwise hold.
REQ-017 SHALL, in FULL: on consume, go to ONE with MAIN <= SKID; otherwise hold both entries unchanged.
REQ-018 SHALL drive IN_READY = 1 in EMPTY and ONE and 0 in FULL, with IN_READY registered from next-state.
REQ-019 SHALL drive OUT_VALID = 1 in ONE and FULL and 0 in EMPTY; OCCUPANCY SHALL equal the entry count.
REQ-020 SHALL give a latency of exactly one cycle from accept to OUT_VALID when the stage was EMPTY.
REQ-021 SHALL, when the stage is held with OUT_VALID = 1 and OUT_READY = 0, keep OUT_DATA stable.
REQ-022 SHALL preserve payload order; no payload may be dropped or duplicated except by FLUSH.
REQ-023 SHALL give FLUSH priority over all other events: the next state is EMPTY, MAIN <= RESET_DATA, SKID is invalid, IN_READY = 1, and any accept or consume in that cycle is discarded.
REQ-024 SHALL keep MAIN at its last value in EMPTY when no flush occurred (don't-care contents, OUT_VALID = 0).
REQ-025 SHALL sustain a throughput of one payload per cycle with OUT_READY held at 1.

Reset
REQ-026 SHALL, on RESET low, immediately force state EMPTY, MAIN <= RESET_DATA, SKID <= RESET_DATA, IN_READY = 1, OUT_VALID = 0 and OCCUPANCY = 0, independent of CLOCK.
REQ-027 SHALL, when RESET is asserted mid-operation, lose held entries without producing any spurious OUT_VALID pulse; the first accept after release SHALL behave as from EMPTY.

Structure
REQ-028 SHALL take its state encoding (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2) and its default NOP payload constant from the shared pipeline package used by all stage registers.
REQ-029 SHALL be a single module with no sub-modules; the IF/ID, ID/EX, EX/MEM and MEM/WB stages instantiate it with their own WIDTH.

Verification
REQ-030 SHALL verify reset: RESET low for 2 cycles with RESET_DATA = 0 -> OUT_DATA = 0, OUT_VALID = 0, IN_READY = 1, OCCUPANCY = 0 asynchronously.
REQ-031 SHALL verify streaming: 4 payloads 0x1..0x4 on consecutive cycles with OUT_READY = 1 -> the same 4 payloads appear in order one cycle later, with OCCUPANCY never exceeding 1.
REQ-032 SHALL verify backpressure: with OUT_READY = 0, send 0xA then 0xB -> OCCUPANCY = 2, IN_READY = 0, OUT_DATA = 0xA held; then raise OUT_READY -> 0xA then 0xB delivered and IN_READY returns to 1.
REQ-033 SHALL verify flush in FULL: FLUSH with simultaneous IN_VALID (0xC) and OUT_READY -> next cycle OCCUPANCY = 0, OUT_DATA = RESET_DATA, and 0xC is never output.
REQ-034 SHALL verify reset mid-operation: in FULL, pulse RESET low between clock edges -> outputs reach reset values before the next edge, with no OUT_VALID afterwards until a new accept.
REQ-035 SHALL verify randomized valid/ready over 10,000 cycles against a reference FIFO model -> no loss, duplication or reordering, and IN_READY never combinationally follows OUT_READY.
